// File: rtl/hood_mode_if.sv
// Button inputs and mode outputs of the range-hood mode controller.
// The master side drives the buttons; the slave side is the controller.
interface hood_mode_if #(
    parameter int CNT_W = 7
);
    logic             menu_btn;
    logic             mode1_btn;
    logic             mode2_btn;
    logic             mode3_btn;
    logic [2:0]       mode_state;
    logic [CNT_W-1:0] countdown;
    logic             hurricane_avail;
    logic             in_menu;

    modport master (
        output menu_btn, mode1_btn, mode2_btn, mode3_btn,
        input  mode_state, countdown, hurricane_avail, in_menu
    );

    modport slave (
        input  menu_btn, mode1_btn, mode2_btn, mode3_btn,
        output mode_state, countdown, hurricane_avail, in_menu
    );
endinterface

// File: rtl/hood_mode_ctrl.sv
// Range-hood fan mode controller on the 1 Hz tick: menu FSM, one-shot
// hurricane with timed auto-drop, and timed return to standby.
//
//  state  | meaning
//  IDLE   | standby, fan off (mode 0)
//  MENU   | menu open, waiting for a level choice (mode 0)
//  L1     | fan level 1
//  L2     | fan level 2
//  HUR    | hurricane (mode 3), counting down to auto-drop to L2
//  RET    | level 2 run-out after menu exit from hurricane, then IDLE
module hood_mode_ctrl #(
    parameter int HURRICANE_SEC = 60,
    parameter int RETURN_SEC    = 60,
    parameter int CNT_W         = 7
) (
    input  logic         clk_1hz,
    input  logic         rst,
    hood_mode_if.slave   hood
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MENU = 3'd1,
        S_L1   = 3'd2,
        S_L2   = 3'd3,
        S_HUR  = 3'd4,
        S_RET  = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] HUR_CNT = CNT_W'(HURRICANE_SEC);
    localparam logic [CNT_W-1:0] RET_CNT = CNT_W'(RETURN_SEC);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             avail_q, avail_d;
    logic [3:0]       btn_prev_q;
    logic [2:0]       mode_q, mode_d;
    logic             in_menu_q, in_menu_d;

    logic [3:0] btn, press;
    logic       menu_p, m3_p, m2_p, m1_p;

    // bit order {menu, mode3, mode2, mode1} matches press priority
    assign btn   = {hood.menu_btn, hood.mode3_btn, hood.mode2_btn, hood.mode1_btn};
    assign press = btn & ~btn_prev_q;

    always_comb begin
        menu_p = press[3];
        m3_p   = press[2] & ~press[3];
        m2_p   = press[1] & ~(|press[3:2]);
        m1_p   = press[0] & ~(|press[3:1]);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        avail_d = avail_q;
        case (state_q)
            S_IDLE: begin
                if (menu_p) state_d = S_MENU;
            end
            S_MENU: begin
                if (menu_p) begin
                    state_d = S_IDLE;
                end else if (m3_p) begin
                    if (avail_q) begin
                        state_d = S_HUR;
                        cnt_d   = HUR_CNT;
                        avail_d = 1'b0;
                    end
                end else if (m2_p) begin
                    state_d = S_L2;
                end else if (m1_p) begin
                    state_d = S_L1;
                end
            end
            S_L1: begin
                if (menu_p)    state_d = S_IDLE;
                else if (m2_p) state_d = S_L2;
            end
            S_L2: begin
                if (menu_p)    state_d = S_IDLE;
                else if (m1_p) state_d = S_L1;
            end
            S_HUR: begin
                // menu beats expiry; a zero count is treated as expired so it never wraps
                if (menu_p) begin
                    state_d = S_RET;
                    cnt_d   = RET_CNT;
                end else if (cnt_q <= CNT_ONE) begin
                    state_d = S_L2;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_RET: begin
                if (cnt_q <= CNT_ONE) state_d = S_IDLE;
                else                  cnt_d   = cnt_q - CNT_ONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mode_d    = 3'd0;
        in_menu_d = (state_d == S_MENU);
        case (state_d)
            S_L1:         mode_d = 3'd1;
            S_L2, S_RET:  mode_d = 3'd2;
            S_HUR:        mode_d = 3'd3;
            default:      mode_d = 3'd0;
        endcase
    end

    // button history resets high so a button held through reset is not a press
    always_ff @(posedge clk_1hz or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            avail_q    <= 1'b1;
            btn_prev_q <= 4'hF;
            mode_q     <= 3'd0;
            in_menu_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            avail_q    <= avail_d;
            btn_prev_q <= btn;
            mode_q     <= mode_d;
            in_menu_q  <= in_menu_d;
        end
    end

    assign hood.mode_state      = mode_q;
    assign hood.countdown       = cnt_q;
    assign hood.hurricane_avail = avail_q;
    assign hood.in_menu         = in_menu_q;

endmodule

// File: tb/tb_hood_mode_ctrl.sv
// Scoreboard bench for hood_mode_ctrl: directed sequences plus random
// button activity, checked against a behavioural model of the hood.
module tb_hood_mode_ctrl;
    localparam int HS = 60;
    localparam int RS = 60;
    localparam int CW = 7;

    logic clk_1hz = 1'b0;
    logic rst     = 1'b0;

    hood_mode_if #(.CNT_W(CW)) hif ();

    hood_mode_ctrl #(
        .HURRICANE_SEC(HS),
        .RETURN_SEC   (RS),
        .CNT_W        (CW)
    ) dut (
        .clk_1hz(clk_1hz),
        .rst    (rst),
        .hood   (hif)
    );

    always #5 clk_1hz = ~clk_1hz;

    typedef struct {
        int mode;
        int cnt;
        int avail;
        int menu;
    } exp_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // model: fan mode number, open menu flag, run-out flag, seconds left
    int       m_mode, m_cnt;
    bit       m_avail, m_menu, m_ret;
    bit [3:0] m_prev;

    task automatic chk(input string name, input int act, input int exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    // b = {menu, mode3, mode2, mode1}
    task automatic model_step(input bit [3:0] b);
        bit [3:0] rise;
        int       w;
        rise   = b & ~m_prev;
        m_prev = b;
        if (rise[3])      w = 4;
        else if (rise[2]) w = 3;
        else if (rise[1]) w = 2;
        else if (rise[0]) w = 1;
        else              w = 0;

        if (m_menu) begin
            if (w == 4) begin
                m_menu = 0;
            end else if (w == 3) begin
                if (m_avail) begin
                    m_menu = 0; m_mode = 3; m_cnt = HS; m_avail = 0;
                end
            end else if (w == 2) begin
                m_menu = 0; m_mode = 2;
            end else if (w == 1) begin
                m_menu = 0; m_mode = 1;
            end
        end else if (m_mode == 3) begin
            if (w == 4) begin
                m_mode = 2; m_ret = 1; m_cnt = RS;
            end else if (m_cnt == 1) begin
                m_mode = 2; m_cnt = 0;
            end else begin
                m_cnt = m_cnt - 1;
            end
        end else if (m_ret) begin
            if (m_cnt == 1) begin
                m_ret = 0; m_mode = 0; m_cnt = 0;
            end else begin
                m_cnt = m_cnt - 1;
            end
        end else if (m_mode == 0) begin
            if (w == 4) m_menu = 1;
        end else if (m_mode == 1) begin
            if (w == 4)      m_mode = 0;
            else if (w == 2) m_mode = 2;
        end else begin
            if (w == 4)      m_mode = 0;
            else if (w == 1) m_mode = 1;
        end
    endtask

    task automatic set_btn(input bit [3:0] b);
        hif.menu_btn  = b[3];
        hif.mode3_btn = b[2];
        hif.mode2_btn = b[1];
        hif.mode1_btn = b[0];
    endtask

    task automatic drive_step(input bit [3:0] b);
        set_btn(b);
        model_step(b);
        sbq.push_back('{m_mode, m_cnt, int'(m_avail), int'(m_menu)});
    endtask

    task automatic cycle(input bit [3:0] b);
        @(negedge clk_1hz);
        drive_step(b);
    endtask

    task automatic do_reset(input bit [3:0] held);
        @(negedge clk_1hz);
        set_btn(held);
        #2 rst = 1'b0;
        #1;
        chk("rst_mode",    int'(hif.mode_state),      0);
        chk("rst_count",   int'(hif.countdown),       0);
        chk("rst_avail",   int'(hif.hurricane_avail), 1);
        chk("rst_in_menu", int'(hif.in_menu),         0);
        repeat (2) @(negedge clk_1hz);
        rst     = 1'b1;
        m_mode  = 0; m_cnt = 0; m_avail = 1; m_menu = 0; m_ret = 0;
        m_prev  = 4'hF;
        drive_step(held);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_1hz);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("mode_state",      int'(hif.mode_state),      e.mode);
                chk("countdown",       int'(hif.countdown),       e.cnt);
                chk("hurricane_avail", int'(hif.hurricane_avail), e.avail);
                chk("in_menu",         int'(hif.in_menu),         e.menu);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: time limit reached, scoreboard depth %0d expected 0", sbq.size());
        $fatal(1, "bench timed out");
    end

    initial begin : stim
        set_btn(4'h0);
        do_reset(4'h0);

        cycle(4'b1000);                 // menu
        cycle(4'b0001);                 // level 1
        cycle(4'b0000);
        cycle(4'b1000);                 // back to standby
        cycle(4'b0000);
        cycle(4'b1000);
        cycle(4'b0100);                 // hurricane
        repeat (HS + 2) cycle(4'b0000);

        cycle(4'b1000);
        cycle(4'b0000);
        cycle(4'b1000);
        cycle(4'b0100);                 // hurricane already used
        cycle(4'b0010);                 // level 2
        cycle(4'b0000);
        cycle(4'b1001);                 // menu beats mode1
        cycle(4'b0000);
        repeat (5) cycle(4'b1000);      // held menu acts once
        cycle(4'b0000);

        do_reset(4'h0);
        cycle(4'b1000);
        cycle(4'b0100);
        repeat (HS / 2) cycle(4'b0000);
        cycle(4'b1000);                 // exit hurricane at 30 s left
        repeat (RS + 5) cycle(4'($urandom_range(0, 15)));
        cycle(4'b0000);
        cycle(4'b1000);
        cycle(4'b0100);
        cycle(4'b0000);

        do_reset(4'h0);
        cycle(4'b1000);
        cycle(4'b0100);
        repeat (10) cycle(4'b0000);
        do_reset(4'b1010);              // menu and mode2 held through release
        cycle(4'b1010);
        cycle(4'b0000);

        for (int i = 0; i < 1500; i++) begin
            bit [3:0] b;
            for (int k = 0; k < 4; k++) b[k] = ($urandom_range(0, 3) == 0);
            if ((i % 250) == 249) do_reset(b);
            else                  cycle(b);
        end

        @(negedge clk_1hz);
        @(negedge clk_1hz);
        chk("scoreboard_drain", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
